// File: rtl/iir_sample_server.sv
// Sample buffer server for a streaming IIR filter: the host fills a block, the filter reads it with
// zero-padding past the end, and the filter outputs are captured with a running checksum.
module iir_sample_server #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned ADDR_W     = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  h_start,
  input  logic [DEPTH_LOG2:0]   h_len,
  input  logic                  h_wr_en,
  input  logic [15:0]           h_wr_data,
  output logic                  h_wr_ready,
  input  logic [DEPTH_LOG2-1:0] h_rd_addr,
  output logic [15:0]           h_rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           checksum,
  output logic [DEPTH_LOG2:0]   out_count,
  output logic                  f_rst,
  input  logic                  load,
  input  logic [ADDR_W-1:0]     RAddr,
  output logic [15:0]           DIn,
  input  logic                  WEN,
  input  logic [ADDR_W-1:0]     WAddr,
  input  logic [15:0]           Yn,
  output logic                  data_done,
  input  logic                  Finish
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DepthLen = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [2:0] {StIdle, StFill, StRun, StWaitFin, StDone} state_e;

  state_e                state_q;
  logic [DEPTH_LOG2:0]   len_q;
  logic [DEPTH_LOG2:0]   ptr_q;
  logic [15:0]           in_mem  [DEPTH];
  logic [15:0]           out_mem [DEPTH];

  logic              start_ok;
  logic              wr_fire;
  logic              fill_last;
  logic              cap;
  logic              cap_last;
  logic [ADDR_W-1:0] len_ext;

  assign len_ext    = ADDR_W'(len_q);
  assign h_wr_ready = (state_q == StFill);
  assign start_ok   = h_start && (h_len != '0) && (h_len <= DepthLen) &&
                      ((state_q == StIdle) || (state_q == StDone));
  assign wr_fire    = h_wr_en && h_wr_ready;
  assign fill_last  = wr_fire && (ptr_q == len_q - 1'b1);
  assign cap        = (state_q == StRun) && WEN && (WAddr < len_ext);
  assign cap_last   = cap && (WAddr == len_ext - 1'b1);

  // Reads past the block end return zero so the filter can drain its history.
  assign DIn = (load && (RAddr < len_ext)) ? in_mem[RAddr[DEPTH_LOG2-1:0]] : 16'h0000;

  always_ff @(posedge clk) begin
    if (wr_fire) in_mem[ptr_q[DEPTH_LOG2-1:0]] <= h_wr_data;
    if (cap)     out_mem[WAddr[DEPTH_LOG2-1:0]] <= Yn;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) h_rd_data <= 16'h0000;
    else     h_rd_data <= out_mem[h_rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      len_q     <= '0;
      ptr_q     <= '0;
      f_rst     <= 1'b1;
      data_done <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      checksum  <= '0;
      out_count <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start_ok) begin
            state_q   <= StFill;
            len_q     <= h_len;
            ptr_q     <= '0;
            checksum  <= '0;
            out_count <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        StFill: begin
          if (wr_fire) begin
            ptr_q <= ptr_q + 1'b1;
            if (fill_last) begin
              state_q <= StRun;
              f_rst   <= 1'b0;
            end
          end
        end
        StRun: begin
          if (cap) begin
            out_count <= out_count + 1'b1;
            checksum  <= checksum + {{16{Yn[15]}}, Yn};
            if (cap_last) begin
              state_q   <= StWaitFin;
              data_done <= 1'b1;
            end
          end
        end
        StWaitFin: begin
          if (Finish) begin
            state_q   <= StDone;
            f_rst     <= 1'b1;
            data_done <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_sample_server.sv
// Randomized bench for iir_sample_server: a scripted filter stub drives the RUN phase while a
// plain array/sum model predicts DIn, the captured buffer, checksum and counters.
module tb_iir_sample_server;

  logic        clk = 1'b0;
  logic        rst;
  logic        h_start;
  logic [10:0] h_len;
  logic        h_wr_en;
  logic [15:0] h_wr_data;
  logic        h_wr_ready;
  logic [9:0]  h_rd_addr;
  logic [15:0] h_rd_data;
  logic        busy;
  logic        done;
  logic [31:0] checksum;
  logic [10:0] out_count;
  logic        f_rst;
  logic        load;
  logic [19:0] RAddr;
  logic [15:0] DIn;
  logic        WEN;
  logic [19:0] WAddr;
  logic [15:0] Yn;
  logic        data_done;
  logic        Finish;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] smp     [1024];
  logic [15:0] exp_out [1024];
  logic [31:0] exp_sum;
  int          exp_cnt;

  iir_sample_server dut (
    .clk       (clk),
    .rst       (rst),
    .h_start   (h_start),
    .h_len     (h_len),
    .h_wr_en   (h_wr_en),
    .h_wr_data (h_wr_data),
    .h_wr_ready(h_wr_ready),
    .h_rd_addr (h_rd_addr),
    .h_rd_data (h_rd_data),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum),
    .out_count (out_count),
    .f_rst     (f_rst),
    .load      (load),
    .RAddr     (RAddr),
    .DIn       (DIn),
    .WEN       (WEN),
    .WAddr     (WAddr),
    .Yn        (Yn),
    .data_done (data_done),
    .Finish    (Finish)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full block: start, fill from smp[], filter stub pass, Finish, read-back of out_mem.
  task automatic run_block(input int len, input bit yn_ones, input int abort_at,
                           input bit dup_start);
    // Host write colliding with h_start must be dropped.
    h_start = 1'b1; h_len = 11'(len); h_wr_en = 1'b1; h_wr_data = 16'hdead;
    tick();
    h_start = 1'b0; h_wr_en = 1'b0;
    exp_sum = '0; exp_cnt = 0;
    check("start_busy", 32'(busy), 1);
    check("start_done", 32'(done), 0);
    check("start_count", 32'(out_count), 0);
    check("start_sum", checksum, 0);
    check("start_wr_ready", 32'(h_wr_ready), 1);

    for (int i = 0; i < len; i++) begin
      h_wr_en = 1'b1; h_wr_data = smp[i];
      if (dup_start && i == 0) begin
        h_start = 1'b1; h_len = 11'd5;
      end
      tick();
      h_start = 1'b0;
      if (i < len - 1) check("fill_f_rst", 32'(f_rst), 1);
    end
    h_wr_en = 1'b0;
    check("run_f_rst", 32'(f_rst), 0);
    check("run_wr_ready", 32'(h_wr_ready), 0);

    for (int c = 0; c <= len + 2; c++) begin
      logic [15:0] y;
      if (abort_at > 0 && c == abort_at + 1) begin
        check("abort_count", 32'(out_count), 32'(abort_at));
        rst = 1'b1;
        #1;
        check("rst_f_rst", 32'(f_rst), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_data_done", 32'(data_done), 0);
        check("rst_sum", checksum, 0);
        check("rst_count", 32'(out_count), 0);
        rst = 1'b0; load = 1'b0; WEN = 1'b0; Finish = 1'b0;
        return;
      end
      y = yn_ones ? 16'hffff : 16'($urandom);
      load = 1'b1; RAddr = 20'(c);
      WEN = (c <= len + 1);
      WAddr = (c == 0) ? 20'(len + $urandom_range(0, 7)) : 20'(c - 1);
      Yn = y;
      Finish = (c == len + 1);
      if (c >= 1 && c <= len) begin
        exp_out[c-1] = y;
        exp_sum += {{16{y[15]}}, y};
        exp_cnt++;
      end
      #1;
      check("din", 32'(DIn), (c < len) ? 32'(smp[c]) : 32'd0);
      tick();
      check("data_done", 32'(data_done), 32'(c == len));
      check("f_rst", 32'(f_rst), 32'(c >= len + 1));
      check("out_count", 32'(out_count), 32'(exp_cnt));
    end
    load = 1'b0; WEN = 1'b0; Finish = 1'b0;
    check("end_done", 32'(done), 1);
    check("end_busy", 32'(busy), 0);
    check("end_sum", checksum, exp_sum);

    for (int i = 0; i < len; i++) begin
      h_rd_addr = 10'(i);
      tick();
      check("h_rd_data", 32'(h_rd_data), 32'(exp_out[i]));
    end
  endtask

  task automatic fill_random(input int len);
    for (int i = 0; i < len; i++) smp[i] = 16'($urandom);
  endtask

  initial begin
    int len;
    rst = 1'b1; h_start = 1'b0; h_len = '0; h_wr_en = 1'b0; h_wr_data = '0; h_rd_addr = '0;
    load = 1'b0; RAddr = '0; WEN = 1'b0; WAddr = '0; Yn = '0; Finish = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_f_rst", 32'(f_rst), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_data_done", 32'(data_done), 0);
    check("rst_sum", checksum, 0);
    check("rst_count", 32'(out_count), 0);
    check("rst_rd_data", 32'(h_rd_data), 0);
    check("rst_din", 32'(DIn), 0);
    rst = 1'b0;
    tick();

    // Finish outside WAIT_FIN and illegal lengths are ignored.
    Finish = 1'b1; tick(); Finish = 1'b0;
    check("idle_finish_done", 32'(done), 0);
    h_start = 1'b1; h_len = 11'd0; tick();
    check("len0_busy", 32'(busy), 0);
    h_len = 11'd1025; tick();
    check("len1025_busy", 32'(busy), 0);
    check("len1025_wr_ready", 32'(h_wr_ready), 0);
    h_start = 1'b0;

    smp[0] = 16'h1234;
    run_block(1, 1'b0, 0, 1'b0);

    smp[0] = 16'h4000; smp[1] = 16'h0000; smp[2] = 16'hc000; smp[3] = 16'h0001;
    run_block(4, 1'b0, 0, 1'b0);

    fill_random(3);
    run_block(3, 1'b1, 0, 1'b0);
    check("ones_sum", checksum, 32'hffff_fffd);
    check("ones_count", 32'(out_count), 3);

    fill_random(2);
    run_block(2, 1'b0, 0, 1'b1);

    fill_random(10);
    run_block(10, 1'b0, 5, 1'b0);
    fill_random(10);
    run_block(10, 1'b0, 0, 1'b0);
    check("rerun_count", 32'(out_count), 10);

    fill_random(8);
    run_block(8, 1'b0, 0, 1'b0);

    repeat (4) begin
      len = $urandom_range(1, 40);
      fill_random(len);
      run_block(len, 1'b0, 0, 1'b0);
    end

    fill_random(1024);
    run_block(1024, 1'b0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
